// File: rtl/cpu_ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage with HI/LO result registers.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module cpu_ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cpu_stall_i,
    input  logic             int_flush_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 div_q;
    logic                 sgn_q;
    logic                 rsgn_q;
    logic                 div0_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     x_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    logic                 x_neg, y_neg;
    logic [WIDTH-1:0]     x_mag, y_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_part;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     b_d;
    logic                 run_exit;
    logic [2*WIDTH-1:0]   prod_mag;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     fix_hi_d;
    logic [WIDTH-1:0]     fix_lo_d;

    // op_i[0] clear means a signed operation
    assign x_neg = ~op_i[0] & x_i[WIDTH-1];
    assign y_neg = ~op_i[0] & y_i[WIDTH-1];
    assign x_mag = x_neg ? -x_i : x_i;
    assign y_mag = y_neg ? -y_i : y_i;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{b_q[0]}} & a_q};
        div_part = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
        div_diff = div_part - {1'b0, a_q};
        div_ge   = ~div_diff[WIDTH];
        acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
        b_d      = b_q >> 1;
        if (div_q) begin
            // Divide keeps the partial remainder in the low half and shifts quotient bits into b_q
            acc_d = {{WIDTH{1'b0}}, (div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0])};
            b_d   = {b_q[WIDTH-2:0], div_ge};
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0] shift_left;
    assign run_exit   = (cnt_q == LAST) || (!div_q && (b_d == '0));
    assign shift_left = LAST - cnt_q;
    assign prod_mag   = acc_q >> shift_left;
`else
    assign run_exit   = (cnt_q == LAST);
    assign prod_mag   = acc_q;
`endif

    always_comb begin
        prod = sgn_q ? -prod_mag : prod_mag;
        quo  = sgn_q ? -b_q : b_q;
        rem  = rsgn_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (div0_q) begin
            fix_hi_d = x_q;
            fix_lo_d = '1;
        end else if (div_q) begin
            fix_hi_d = rem;
            fix_lo_d = quo;
        end else begin
            fix_hi_d = prod[2*WIDTH-1:WIDTH];
            fix_lo_d = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            rsgn_q  <= 1'b0;
            div0_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else if (!cpu_stall_i) begin
            done_q <= 1'b0;
            if (int_flush_i) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (hi_we_i) hi_q <= wdata_i;
                        if (lo_we_i) lo_q <= wdata_i;
                        if (start_i) begin
                            div_q   <= op_i[1];
                            sgn_q   <= x_neg ^ y_neg;
                            rsgn_q  <= x_neg;
                            div0_q  <= op_i[1] && (y_i == '0);
                            a_q     <= op_i[1] ? y_mag : x_mag;
                            b_q     <= op_i[1] ? x_mag : y_mag;
                            x_q     <= x_i;
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        acc_q <= acc_d;
                        b_q   <= b_d;
                        // Counter is held on exit so FIX knows how many shifts were skipped
                        if (run_exit) state_q <= S_FIX;
                        else          cnt_q   <= cnt_q + CNT_ONE;
                    end
                    S_FIX: begin
                        hi_q    <= fix_hi_d;
                        lo_q    <= fix_lo_d;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_cpu_ex_muldiv.sv
// Self-checking bench for cpu_ex_muldiv: scoreboard of expected {hi,lo} popped on each done pulse.
module tb_cpu_ex_muldiv;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_stall, int_flush, start, hi_we, lo_we;
    logic [1:0]    op;
    logic [W-1:0]  x, y, wdata;
    logic          busy_o, done_o;
    logic [W-1:0]  hi_o, lo_o;

    int errors = 0;
    int checks = 0;
    logic [2*W-1:0] sb_q[$];
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    cpu_ex_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i(clk), .rst_ni(rst_n), .cpu_stall_i(cpu_stall), .int_flush_i(int_flush),
        .start_i(start), .op_i(op), .x_i(x), .y_i(y), .hi_we_i(hi_we), .lo_we_i(lo_we),
        .wdata_i(wdata), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    // Scoreboard monitor: one pop per rising done
    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done_o && !done_prev) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got hi=%h lo=%h required no done", hi_o, lo_o);
                end else begin
                    logic [2*W-1:0] e;
                    e = sb_q.pop_front();
                    if ({hi_o, lo_o} !== e) begin
                        errors++;
                        $display("FAIL result got hi=%h lo=%h required hi=%h lo=%h",
                                 hi_o, lo_o, e[2*W-1:W], e[W-1:0]);
                    end
                end
            end
            done_prev = done_o;
        end
    end

    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sp;
        logic signed [W-1:0]   sa, sb, q, r;
        sa = a;
        sb = b;
        case (o)
            2'd0: begin
                sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                return sp;
            end
            2'd1: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            2'd2: begin
                if (b == '0) return {a, {W{1'b1}}};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        logic [W-1:0] m;
        int n;
        if (o[1]) return W + 1;
        m = (o == 2'd0 && b[W-1]) ? -b : b;
        n = 0;
        while (m != '0) begin
            n++;
            m = m >> 1;
        end
        if (n == 0) n = 1;
        return n + 1;
`else
        return W + 1 + 0 * int'(o) + 0 * int'(b[0]);
`endif
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic [2*W-1:0] ev, input int lat, input int stall_at,
                         input int stall_len, input bit mt, input bit spur, input string nm);
        int  n;
        bit  got;
        @(negedge clk);
        op = o; x = xv; y = yv; start = 1'b1;
        if (mt) begin hi_we = 1'b1; wdata = 32'h0000_ABCD; end
        sb_q.push_back(ev);
        @(posedge clk);
        #1 start = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_start got %b required 1", nm, busy_o);
        end
        if (mt) begin
            checks++;
            if (hi_o !== 32'h0000_ABCD) begin
                errors++;
                $display("FAIL %s_mthi_with_start got %h required 0000abcd", nm, hi_o);
            end
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            if (stall_len > 0 && n == stall_at) cpu_stall = 1'b1;
            if (stall_len > 0 && n == stall_at + stall_len) cpu_stall = 1'b0;
            if (spur && n == 5) begin start = 1'b1; op = 2'd3; x = 100; y = 7; end
            if (spur && n == 6) start = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_o) got = 1'b1;
        end
        cpu_stall = 1'b0;
        start = 1'b0;
        checks++;
        if (!got || n != lat) begin
            errors++;
            $display("FAIL %s_latency got %0d (done=%b) required %0d", nm, n, got, lat);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done got %b required 0", nm, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_stall = 0; int_flush = 0; start = 0; hi_we = 0; lo_we = 0;
        op = 0; x = 0; y = 0; wdata = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, done_o, hi_o, lo_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h required all 0", busy_o, done_o, hi_o, lo_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001},
              exp_lat(2'd1, 32'hFFFF_FFFF), 0, 0, 0, 0, "multu_max");
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1},
              exp_lat(2'd0, 32'd5), 0, 0, 0, 0, "mult_neg");
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, model(2'd0, 32'h8000_0000, 32'h8000_0000),
              exp_lat(2'd0, 32'h8000_0000), 0, 0, 0, 0, "mult_minmin");
    endtask

    task automatic test_div();
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, W + 1, 0, 0, 0, 0, "div_neg");
        do_op(2'd3, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF}, W + 1, 0, 0, 0, 0, "divu_zero");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, W + 1, 0, 0, 0, 0, "div_zero");
        do_op(2'd2, 32'd7, 32'hFFFF_FFFE, model(2'd2, 32'd7, 32'hFFFF_FFFE), W + 1, 0, 0, 0, 0, "div_negdiv");
    endtask

    task automatic test_stall_overflow();
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, W + 6, 10, 5, 0, 0, "div_ovf_stall");
    endtask

    task automatic test_back_to_back();
        do_op(2'd1, 32'd7, 32'd6, {32'h0, 32'd42}, exp_lat(2'd1, 32'd6), 0, 0, 1, 0, "mthi_start");
        do_op(2'd1, 32'd3, 32'd3, {32'h0, 32'd9}, exp_lat(2'd1, 32'd3), 0, 0, 0, 1, "start_busy");
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_op(o, a, b, model(o, a, b), exp_lat(o, b), 0, 0, 0, 0, "random");
        end
    endtask

    task automatic test_flush();
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0;
        @(negedge clk); lo_we = 1'b0;
        checks++;
        if (hi_o !== 32'h1234 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL mthi_mtlo got hi=%h lo=%h required hi=00001234 lo=00000000", hi_o, lo_o);
        end
        op = 2'd1; x = 2; y = 3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin hi_we = 1'b1; wdata = 32'hDEAD; end
            if (i == 4) hi_we = 1'b0;
        end
        int_flush = 1'b1;
        @(posedge clk);
        #1 int_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'h1234 || lo_o !== 32'h0) begin
            errors++;
            $display("FAIL flush got busy=%b done=%b hi=%h lo=%h required 0 0 00001234 00000000",
                     busy_o, done_o, hi_o, lo_o);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk); hi_we = 1'b1; wdata = 32'h55;
        @(negedge clk); hi_we = 1'b0;
        op = 2'd1; x = 9; y = 9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, hi_o, lo_o} !== '0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h required all 0", busy_o, done_o, hi_o, lo_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_early_out();
        do_op(2'd1, 32'd5, 32'd3, {32'h0, 32'd15}, exp_lat(2'd1, 32'd3), 0, 0, 0, 0, "multu_5x3");
        do_op(2'd1, 32'hDEAD_BEEF, 32'd0, 64'h0, exp_lat(2'd1, 32'd0), 0, 0, 0, 0, "multu_by0");
        do_op(2'd1, 32'hDEAD_BEEF, 32'd1, {32'h0, 32'hDEAD_BEEF}, exp_lat(2'd1, 32'd1), 0, 0, 0, 0, "multu_by1");
        do_op(2'd0, 32'd7, 32'hFFFF_FFFF, {32'hFFFF_FFFF, 32'hFFFF_FFF9},
              exp_lat(2'd0, 32'hFFFF_FFFF), 0, 0, 0, 0, "mult_byneg1");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_early_out();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
